// File: rtl/ex_mul_unit.sv
// ex_mul_unit -- iterative shift-add multiplier for the execute stage.
//
// Accepts a multiply flagged by EX_mul, latches operands/rd/we, stalls decode
// while it iterates one multiplier bit per cycle, then strobes the low XLEN
// bits of the product for one cycle to the EX/MEM result mux.
//
// Optional feature macro: MUL_EARLY_TERM_EN
//   defined   -> BUSY exits once the remaining multiplier bits are all zero
//   undefined -> BUSY always runs XLEN cycles
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   EX_a, EX_b    multiplicand / multiplier from the D->EX register
//   EX_mul        instruction in EX is a multiply
//   EX_rd, EX_we  destination register and write enable of that instruction
//   MUL_stall     holds fetch/decode (combinational)
//   MUL_valid     one-cycle product strobe
//   MUL_res       low XLEN bits of a*b (0 outside DONE)
//   MUL_rd        latched rd (0 outside DONE)
//   MUL_we        latched we, forced low when rd is x0 (0 outside DONE)
module ex_mul_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] EX_a,
  input  logic [XLEN-1:0] EX_b,
  input  logic            EX_mul,
  input  logic [4:0]      EX_rd,
  input  logic            EX_we,
  output logic            MUL_stall,
  output logic            MUL_valid,
  output logic [XLEN-1:0] MUL_res,
  output logic [4:0]      MUL_rd,
  output logic            MUL_we
);

  localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   mplr_q,  mplr_d;
  logic [XLEN-1:0]   acc_q,   acc_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [4:0]        rd_q,    rd_d;
  logic              we_q,    we_d;
  logic              last_iter;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
    end
  end

  // Final BUSY iteration: counter exhausted, or (optionally) nothing left to add.
`ifdef MUL_EARLY_TERM_EN
  assign last_iter = (cnt_q == CNT_LAST) || ((mplr_q >> 1) == '0);
`else
  assign last_iter = (cnt_q == CNT_LAST);
`endif

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    we_d      = we_q;
    MUL_stall = 1'b0;
    MUL_valid = 1'b0;
    MUL_res   = '0;
    MUL_rd    = '0;
    MUL_we    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Stall in the start cycle itself so decode holds the next instruction.
        MUL_stall = EX_mul;
        if (EX_mul) begin
          mcand_d = EX_a;
          mplr_d  = EX_b;
          acc_d   = '0;
          cnt_d   = '0;
          rd_d    = EX_rd;
          we_d    = EX_we;
          state_d = BUSY;
        end
      end

      BUSY: begin
        // EX_mul is not looked at here: the stall feeds bubbles into EX.
        MUL_stall = 1'b1;
        if (mplr_q[0]) acc_d = acc_q + mcand_q;  // carry out dropped
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (last_iter) state_d = DONE;
      end

      DONE: begin
        MUL_valid = 1'b1;
        MUL_res   = acc_q;
        MUL_rd    = rd_q;
        MUL_we    = we_q && (rd_q != 5'd0);
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ex_mul_unit.sv
// Directed self-checking bench for ex_mul_unit (XLEN=32).
// Expected latencies follow MUL_EARLY_TERM_EN when the bench is built with it.
module tb_ex_mul_unit;

  logic        clk;
  logic        rst;
  logic [31:0] EX_a, EX_b;
  logic        EX_mul;
  logic [4:0]  EX_rd;
  logic        EX_we;
  logic        MUL_stall, MUL_valid, MUL_we;
  logic [31:0] MUL_res;
  logic [4:0]  MUL_rd;

  int checks   = 0;
  int failures = 0;

  ex_mul_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .EX_a(EX_a), .EX_b(EX_b), .EX_mul(EX_mul), .EX_rd(EX_rd), .EX_we(EX_we),
    .MUL_stall(MUL_stall), .MUL_valid(MUL_valid), .MUL_res(MUL_res),
    .MUL_rd(MUL_rd), .MUL_we(MUL_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a multiply in the current cycle (T) and run until MUL_valid or a
  // 40-cycle bound. lat = k where MUL_valid is seen in T+k (0 if never).
  // Returns in the DONE cycle with EX_mul low. junk drives EX_mul high with
  // garbage operands while the unit is busy.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic we, input bit junk,
                         output int lat, output int stalls,
                         output logic [31:0] res, output logic [4:0] ord,
                         output logic owe);
    lat = 0; stalls = 0; res = 'x; ord = 'x; owe = 1'bx;
    EX_a = a; EX_b = b; EX_rd = rd; EX_we = we; EX_mul = 1'b1;
    #0;
    if (MUL_stall) stalls++;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (junk) begin
        EX_mul = 1'b1; EX_a = 32'hDEAD_BEEF; EX_b = 32'h0BAD_F00D; EX_rd = 5'd31; EX_we = 1'b0;
      end else begin
        EX_mul = 1'b0; EX_a = '0; EX_b = '0; EX_rd = '0; EX_we = 1'b0;
      end
      #0;
      if (MUL_stall) stalls++;
      if (MUL_valid) begin
        lat = k; res = MUL_res; ord = MUL_rd; owe = MUL_we;
        EX_mul = 1'b0;
        break;
      end
    end
    EX_mul = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; EX_mul = 1'b0; EX_a = '0; EX_b = '0; EX_rd = '0; EX_we = 1'b0;
    repeat (3) tick();
    checks++;
    if ({MUL_stall, MUL_valid, MUL_res, MUL_rd, MUL_we} !== 40'd0) begin
      failures++;
      $display("FAIL reset_outputs got stall=%b valid=%b res=%h rd=%0d we=%b want all 0",
               MUL_stall, MUL_valid, MUL_res, MUL_rd, MUL_we);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({MUL_stall, MUL_valid, MUL_res, MUL_rd, MUL_we} !== 40'd0) begin
      failures++;
      $display("FAIL idle_outputs got stall=%b valid=%b res=%h want 0", MUL_stall, MUL_valid, MUL_res);
    end
  endtask

  task automatic test_basic();
    int lat, st; logic [31:0] r; logic [4:0] d; logic w;
    run_mul(32'd7, 32'd6, 5'd5, 1'b1, 1'b0, lat, st, r, d, w);
    checks++;
`ifdef MUL_EARLY_TERM_EN
    if (lat != 4 || st != 4) begin failures++; $display("FAIL basic_latency got lat=%0d stall=%0d want 4/4", lat, st); end
`else
    if (lat != 33 || st != 33) begin failures++; $display("FAIL basic_latency got lat=%0d stall=%0d want 33/33", lat, st); end
`endif
    checks++;
    if (r !== 32'd42 || d !== 5'd5 || w !== 1'b1) begin
      failures++; $display("FAIL basic_result got res=%0d rd=%0d we=%b want 42/5/1", r, d, w);
    end
    tick();  // one-cycle strobe: back to IDLE, outputs cleared
    checks++;
    if ({MUL_valid, MUL_res, MUL_rd, MUL_we, MUL_stall} !== 40'd0) begin
      failures++; $display("FAIL basic_strobe_clear got valid=%b res=%h rd=%0d want 0", MUL_valid, MUL_res, MUL_rd);
    end
  endtask

  task automatic test_wrap();
    int lat, st; logic [31:0] r; logic [4:0] d; logic w;
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b1, 1'b0, lat, st, r, d, w);
    checks++;
    if (r !== 32'h0000_0001 || lat != 33) begin
      failures++; $display("FAIL wrap_ones got res=%h lat=%0d want 00000001/33", r, lat);
    end
    tick();
    run_mul(32'h0001_0000, 32'h0001_0000, 5'd2, 1'b1, 1'b0, lat, st, r, d, w);
    checks++;
`ifdef MUL_EARLY_TERM_EN
    if (r !== 32'h0 || lat != 18) begin failures++; $display("FAIL wrap_carry got res=%h lat=%0d want 00000000/18", r, lat); end
`else
    if (r !== 32'h0 || lat != 33) begin failures++; $display("FAIL wrap_carry got res=%h lat=%0d want 00000000/33", r, lat); end
`endif
    tick();
  endtask

  task automatic test_rd_zero();
    int lat, st; logic [31:0] r; logic [4:0] d; logic w;
    run_mul(32'd9, 32'd11, 5'd0, 1'b1, 1'b0, lat, st, r, d, w);
    checks++;
    if (lat == 0 || r !== 32'd99 || d !== 5'd0 || w !== 1'b0) begin
      failures++; $display("FAIL rd_zero got lat=%0d res=%0d rd=%0d we=%b want valid/99/0/0", lat, r, d, w);
    end
    tick();
  endtask

  task automatic test_early_term();
    int lat, st; logic [31:0] r; logic [4:0] d; logic w;
    run_mul(32'h0000_1234, 32'd5, 5'd3, 1'b1, 1'b0, lat, st, r, d, w);
    checks++;
`ifdef MUL_EARLY_TERM_EN
    if (r !== 32'h0000_5B04 || lat != 4 || st != 4) begin failures++; $display("FAIL early_b5 got res=%h lat=%0d st=%0d want 00005b04/4/4", r, lat, st); end
`else
    if (r !== 32'h0000_5B04 || lat != 33) begin failures++; $display("FAIL early_b5 got res=%h lat=%0d want 00005b04/33", r, lat); end
`endif
    tick();
    run_mul(32'h1234_5678, 32'd0, 5'd4, 1'b1, 1'b0, lat, st, r, d, w);
    checks++;
`ifdef MUL_EARLY_TERM_EN
    if (r !== 32'h0 || lat != 2) begin failures++; $display("FAIL early_b0 got res=%h lat=%0d want 00000000/2", r, lat); end
`else
    if (r !== 32'h0 || lat != 33) begin failures++; $display("FAIL early_b0 got res=%h lat=%0d want 00000000/33", r, lat); end
`endif
    tick();
    run_mul(32'd3, 32'h8000_0000, 5'd6, 1'b1, 1'b0, lat, st, r, d, w);
    checks++;
    if (r !== 32'h8000_0000 || lat != 33 || st != 33) begin
      failures++; $display("FAIL early_msb got res=%h lat=%0d st=%0d want 80000000/33/33", r, lat, st);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat, st; logic [31:0] r; logic [4:0] d; logic w;
    bit seen_valid;
    seen_valid = 1'b0;
    EX_a = 32'd50; EX_b = 32'hFFFF_FFFF; EX_rd = 5'd7; EX_we = 1'b1; EX_mul = 1'b1;  // cycle T
    for (int k = 1; k <= 10; k++) begin
      tick();
      EX_mul = 1'b0;
      if (MUL_valid) seen_valid = 1'b1;
    end
    rst = 1'b1;   // asserted in T+10
    tick();       // T+11
    rst = 1'b0;
    #0;
    checks++;
    if ({MUL_stall, MUL_valid, MUL_res, MUL_rd, MUL_we} !== 40'd0) begin
      failures++; $display("FAIL reset_mid_outputs got stall=%b valid=%b res=%h rd=%0d want 0",
                           MUL_stall, MUL_valid, MUL_res, MUL_rd);
    end
    tick();       // T+12
    run_mul(32'd3, 32'd4, 5'd8, 1'b1, 1'b0, lat, st, r, d, w);
    checks++;
    if (seen_valid || r !== 32'd12 || d !== 5'd8 || lat == 0) begin
      failures++; $display("FAIL reset_mid_restart got res=%0d rd=%0d lat=%0d stale=%b want 12/8/valid/0",
                           r, d, lat, seen_valid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat1, st1, lat2, st2; logic [31:0] r1, r2; logic [4:0] d1, d2; logic w1, w2;
    run_mul(32'h1234_5678, 32'h0000_0010, 5'd9, 1'b1, 1'b0, lat1, st1, r1, d1, w1);
    tick();  // T+lat+1: second multiply starts here
    run_mul(32'd100, 32'd200, 5'd10, 1'b1, 1'b0, lat2, st2, r2, d2, w2);
    checks++;
    if (r1 !== 32'h2345_6780 || d1 !== 5'd9) begin
      failures++; $display("FAIL b2b_first got res=%h rd=%0d want 23456780/9", r1, d1);
    end
    checks++;
    if (r2 !== 32'd20000 || d2 !== 5'd10 || st2 != lat2 || lat2 == 0) begin
      failures++; $display("FAIL b2b_second got res=%0d rd=%0d lat=%0d st=%0d want 20000/10/lat=st", r2, d2, lat2, st2);
    end
`ifndef MUL_EARLY_TERM_EN
    checks++;
    if (lat1 != 33 || lat2 != 33) begin
      failures++; $display("FAIL b2b_latency got %0d/%0d want 33/33", lat1, lat2);
    end
`endif
    tick();
  endtask

  task automatic test_ignored_mul();
    int lat, st; logic [31:0] r; logic [4:0] d; logic w;
    run_mul(32'h0000_ABCD, 32'd3, 5'd12, 1'b1, 1'b1, lat, st, r, d, w);
    checks++;
    if (r !== 32'h0002_0367 || d !== 5'd12 || w !== 1'b1) begin
      failures++; $display("FAIL ignored_mul got res=%h rd=%0d we=%b want 00020367/12/1", r, d, w);
    end
    tick();
    checks++;
    if (MUL_valid !== 1'b0 || MUL_stall !== 1'b0) begin
      failures++; $display("FAIL ignored_mul_idle got valid=%b stall=%b want 0/0", MUL_valid, MUL_stall);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_rd_zero();
    test_early_term();
    test_reset_mid();
    test_back_to_back();
    test_ignored_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mul_unit.md
# ex_mul_unit

Iterative shift-add multiplier in the execute stage, directly downstream of the decode-to-execute pipeline register. It accepts a multiply marked by `EX_mul` and latches its operands and destination. It stalls decode while the multiply runs, then presents the low `XLEN` bits of the product for one cycle, together with the latched `rd` and write-enable, to the EX/MEM result mux.

## Interface
- `XLEN`, default 32, operand and result width.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `EX_a` in XLEN: multiplicand from the D→EX register.
- `EX_b` in XLEN: multiplier from the D→EX register.
- `EX_mul` in 1: the instruction in EX is a multiply.
- `EX_rd` in 5: destination register of that instruction.
- `EX_we` in 1: register write enable of that instruction.
- `MUL_stall` out 1: holds fetch/decode; drives `stall_D`, so bubbles enter EX.
- `MUL_valid` out 1: one-cycle strobe, product is valid.
- `MUL_res` out XLEN: low XLEN bits of a×b.
- `MUL_rd` out 5: latched destination register.
- `MUL_we` out 1: latched write enable, forced to 0 when `MUL_rd` is 0.

## Operation
- Three states: IDLE, BUSY, DONE. Registers:
  - `mcand` (XLEN)
  - `mplr` (XLEN)
  - `acc` (XLEN)
  - `cnt` ($clog2(XLEN) bits)
  - `rd_q`
  - `we_q`
- **IDLE:**
  - If `EX_mul`=1: `mcand`←`EX_a`, `mplr`←`EX_b`, `acc`←0, `cnt`←0, `rd_q`←`EX_rd`, `we_q`←`EX_we`; go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY, each cycle:**
  - If `mplr[0]`: `acc`←`acc`+`mcand`, mod 2^XLEN with the carry discarded.
  - `mcand`←`mcand`<<1, `mplr`←`mplr`>>1, `cnt`←`cnt`+1.
  - Go to DONE when `cnt`==XLEN-1. With `MUL_EARLY_TERM_EN` defined, also go to DONE when the shifted multiplier (`mplr`>>1) is zero.
- **DONE:**
  - `MUL_valid`=1, `MUL_res`=`acc`, `MUL_rd`=`rd_q`, `MUL_we`=`we_q` && (`rd_q`≠0).
  - Unconditional return to IDLE.
- Low product only. Signed and unsigned operands give identical bits; there is no high-word support.
- `MUL_stall` = (IDLE && `EX_mul`) || BUSY. It is combinational, so decode holds in the start cycle itself. It is 0 in DONE.
- `EX_mul` is ignored in BUSY and DONE. It cannot legally occur there, because stall causes the D→EX register to insert bubbles.
- Outside DONE: `MUL_valid`=0, `MUL_we`=0, `MUL_res`=0, `MUL_rd`=0.

## Timing
- Reset: state←IDLE, all datapath registers ←0. Reset values of every output: `MUL_stall`=0, `MUL_valid`=0, `MUL_res`=0, `MUL_rd`=0, `MUL_we`=0.
- `rst` during BUSY or DONE aborts the multiply. Outputs are 0 from the next cycle; no `MUL_valid` is produced for the aborted operation.
- Start cycle T (IDLE, `EX_mul`=1):
  - BUSY occupies T+1 … T+XLEN.
  - DONE and `MUL_valid` fall in cycle T+XLEN+1.
  - `MUL_stall` is high for cycles T … T+XLEN, i.e. XLEN+1 cycles.
- The instruction held in decode enters EX at T+XLEN+2. A back-to-back multiply therefore starts in IDLE at T+XLEN+2.
- With early termination, the number of BUSY cycles = max(1, index of the highest set bit of b + 1), and DONE follows immediately. b=0 or b=1 gives DONE at T+2.
- Latched values are independent of `EX_a`/`EX_b`/`EX_rd` after T, since bubbles arrive from the D→EX register during the stall.

## Configuration
- `MUL_EARLY_TERM_EN`:
  - **Defined:** BUSY exits as soon as the remaining multiplier bits are all zero. Latency is data-dependent, with XLEN+1 stall cycles as the maximum.
  - **Undefined:** the fixed path of XLEN BUSY cycles always runs; latency is always XLEN+1 to DONE.
  - Products are identical either way.

## Test plan
- **Basic multiply.** a=7, b=6, rd=5, we=1, early termination off → `MUL_valid` at T+33 with `MUL_res`=42, `MUL_rd`=5, `MUL_we`=1; `MUL_stall` high for exactly 33 cycles.
- **Wrap-around.**
  - a=b=0xFFFFFFFF → `MUL_res`=0x00000001.
  - a=b=0x00010000 → `MUL_res`=0x00000000; the carry out is discarded.
- **rd=0.** rd=0 with we=1 → `MUL_valid`=1, `MUL_we`=0, `MUL_res` correct.
- **Early termination on.**
  - b=5 → DONE at T+4, `MUL_res`=5a.
  - b=0 → DONE at T+2, `MUL_res`=0.
  - b=0x80000000 → DONE at T+33.
- **Reset mid-operation.** `rst` pulsed at T+10 → no `MUL_valid`; all outputs 0 from T+11. A new multiply at T+12 (a=3, b=4) yields 12.
- **Back-to-back and ignored input.**
  - Two consecutive multiplies: the second starts at T+34 and both results are correct.
  - `EX_mul` forced high during BUSY does not alter the latched operands or the result.
